// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI types, FSM encodings and response helpers for the SRAM-backed AXI3 slave.
package axi_sram_slave_pkg;

    typedef logic [31:0] u32_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LAT,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Response codes are ordered by severity, so the numerically larger one wins.
    function automatic axi_resp_t worse(input axi_resp_t a, input axi_resp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic axi_resp_t resp_of(input logic in_win, input logic size_err);
        if (!in_win)  return RESP_DECERR;
        if (size_err) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// 1R1W synchronous RAM, one byte lane per generated array, 1-cycle read latency.
// The read register holds its value while rd_en is low, which keeps stalled beats stable.
module sram_byte_en #(
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_idx,
    output logic [3:0][7:0]       rd_data,
    input  logic [3:0]            we,
    input  logic [ADDR_W-1:0]     wr_idx,
    input  logic [3:0][7:0]       wr_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[b])
                mem[wr_idx] <= wr_data[b];
            if (rd_en)
                rd_q <= mem[rd_idx];
        end

        assign rd_data[b] = rd_q;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a word-wide SRAM.
// Reads prefetch the next word on each R handshake so bursts can stream one beat per cycle.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int   ADDR_W    = 14,
    parameter u32_t BASE_ADDR = 32'h1c00_0000,
    parameter int   RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    state_t        state;
    grant_t        last_grant;
    u32_t          addr_q;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic          fixed_q;
    logic          size_err_q;
    logic [3:0]    lat_cnt;
    axi_resp_t     wr_resp_q;

    logic          idle;
    logic          ar_hs;
    logic          aw_hs;
    logic          r_hs;
    logic          w_hs;
    logic          last_beat;
    logic          in_win;
    axi_resp_t     beat_resp;
    axi_resp_t     w_resp;
    u32_t          addr_nxt;

    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_idx;
    logic [3:0][7:0]   ram_rd_data;
    logic [3:0]        ram_we;

    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // Ready depends on the competing valid so the round-robin loser sees ready low in the same cycle.
    assign idle    = (state == S_IDLE) && rst_n;
    assign arready = idle && !(awvalid && last_grant == GRANT_READ);
    assign awready = idle && !(arvalid && last_grant == GRANT_WRITE);
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;
    assign r_hs    = rvalid && rready;
    assign w_hs    = wready && wvalid && rst_n;

    assign last_beat = (beat_q == len_q);
    assign in_win    = (addr_q[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign beat_resp = resp_of(in_win, size_err_q);
    assign w_resp    = worse(beat_resp, (wlast != last_beat) ? RESP_SLVERR : RESP_OKAY);

    // Stepping keeps the upper bits, so a burst wraps inside the window instead of leaving it.
    assign addr_nxt = fixed_q ? addr_q
                              : {addr_q[31:ADDR_W+2], addr_q[ADDR_W+1:2] + ADDR_W'(1), addr_q[1:0]};

    assign rlast = rvalid && last_beat;
    assign rresp = rvalid ? beat_resp : RESP_OKAY;
    assign rdata = (rvalid && in_win) ? ram_rd_data : 32'h0;

    assign ram_rd_en  = ar_hs || (r_hs && !last_beat);
    assign ram_rd_idx = ar_hs ? araddr[ADDR_W+1:2] : addr_nxt[ADDR_W+1:2];
    assign ram_we     = (w_hs && in_win) ? wstrb : 4'b0000;

    sram_byte_en #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_idx  (ram_rd_idx),
        .rd_data (ram_rd_data),
        .we      (ram_we),
        .wr_idx  (addr_q[ADDR_W+1:2]),
        .wr_data (wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= GRANT_WRITE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            fixed_q    <= 1'b0;
            size_err_q <= 1'b0;
            lat_cnt    <= '0;
            wr_resp_q  <= RESP_OKAY;
            rvalid     <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            rid        <= '0;
            bid        <= '0;
            bresp      <= RESP_OKAY;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ar_hs) begin
                        rid        <= arid;
                        addr_q     <= araddr;
                        len_q      <= arlen;
                        fixed_q    <= (arburst == BURST_FIXED);
                        size_err_q <= (arsize != SIZE_WORD);
                        beat_q     <= '0;
                        last_grant <= GRANT_READ;
                        if (RD_LAT <= 1) begin
                            state  <= S_RD_DATA;
                            rvalid <= 1'b1;
                        end else begin
                            state   <= S_RD_LAT;
                            lat_cnt <= 4'd1;
                        end
                    end else if (aw_hs) begin
                        bid        <= awid;
                        addr_q     <= awaddr;
                        len_q      <= awlen;
                        fixed_q    <= (awburst == BURST_FIXED);
                        size_err_q <= (awsize != SIZE_WORD);
                        beat_q     <= '0;
                        wr_resp_q  <= RESP_OKAY;
                        last_grant <= GRANT_WRITE;
                        wready     <= 1'b1;
                        state      <= S_WR_DATA;
                    end
                end
                S_RD_LAT: begin
                    if (lat_cnt == 4'(RD_LAT - 1)) begin
                        state  <= S_RD_DATA;
                        rvalid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        if (last_beat) begin
                            rvalid <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_nxt;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_hs) begin
                        wr_resp_q <= worse(wr_resp_q, w_resp);
                        if (last_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= worse(wr_resp_q, w_resp);
                            state  <= S_WR_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_nxt;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: writes, reads, bursts, arbitration, decode errors, reset mid-burst.
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
    logic [1:0]  arlock; logic [3:0] arcache; logic [2:0] arprot; logic arvalid; logic arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast; logic rvalid; logic rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
    logic [1:0]  awlock; logic [3:0] awcache; logic [2:0] awprot; logic awvalid; logic awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast; logic wvalid; logic wready;
    logic [3:0]  bid;    logic [1:0] bresp;   logic bvalid; logic bready;

    int total = 0;
    int bad   = 0;

    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    logic [3:0]  rd_id;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    int          lat;

    always #5 clk = ~clk;

    axi_sram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        logic ok;
        int   g = 0;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        do begin
            @(negedge clk); ok = awready;
            @(posedge clk); #1; g++;
        end while (!ok && g < 50);
        awvalid = 1'b0;
        if (!ok) chk("aw_tmo", {31'b0, ok}, 32'd1);
    endtask

    task automatic w_send(input int len, input int last_at);
        logic ok;
        int   g;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == last_at);
            g = 0;
            do begin
                @(negedge clk); ok = wready;
                @(posedge clk); #1; g++;
            end while (!ok && g < 50);
            if (!ok) chk("w_tmo", {31'b0, ok}, 32'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_get();
        logic ok;
        int   g = 0;
        bready = 1'b1;
        do begin
            @(negedge clk); ok = bvalid; b_resp = bresp; b_id = bid;
            @(posedge clk); #1; g++;
        end while (!ok && g < 50);
        bready = 1'b0;
        if (!ok) chk("b_tmo", {31'b0, ok}, 32'd1);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        logic ok;
        int   g = 0;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        do begin
            @(negedge clk); ok = arready;
            @(posedge clk); #1; g++;
        end while (!ok && g < 50);
        arvalid = 1'b0;
        if (!ok) chk("ar_tmo", {31'b0, ok}, 32'd1);
    endtask

    // Called one step after the AR handshake edge; lat counts cycles until rvalid.
    task automatic r_get(input int len, input logic [15:0] rpat);
        int   nb = 0;
        int   k = 0;
        int   g = 0;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        while (nb <= len && g < 100) begin
            rready = rpat[k % 16]; k++; g++;
            @(negedge clk);
            if (rvalid) begin
                if (stalled) chk("r_hold", rdata, held);
                if (rready) begin
                    rd_d[nb] = rdata; rd_r[nb] = rresp; rd_l[nb] = rlast; rd_id = rid;
                    nb++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = rdata;
                end
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (nb <= len) chk("r_tmo", nb, len + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        awlock = '0; awcache = '0; awprot = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_wready",  {31'b0, wready},  32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rdata",   rdata,            32'h0);
        chk("rst_rid",     {28'b0, rid},     32'h0);
        chk("rst_bresp",   {30'b0, bresp},   32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_arready", {31'b0, arready}, 32'd1);
        chk("idle_awready", {31'b0, awready}, 32'd1);

        // 1: single write then read back
        wdat[0] = 32'hdeadbeef; wstb[0] = 4'b1111;
        aw_send(4'd2, 32'h1c00_0010, 8'd0, 3'b010, 2'b01);
        w_send(0, 0);
        b_get();
        chk("t1_bresp", {30'b0, b_resp}, 32'd0);
        chk("t1_bid",   {28'b0, b_id},   32'd2);
        ar_send(4'd0, 32'h1c00_0010, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t1_lat",   lat, 32'd2);
        chk("t1_rdata", rd_d[0], 32'hdeadbeef);
        chk("t1_rlast", {31'b0, rd_l[0]}, 32'd1);
        chk("t1_rid",   {28'b0, rd_id},   32'd0);
        chk("t1_rresp", {30'b0, rd_r[0]}, 32'd0);

        // 2: byte-lane write merges into existing word
        wdat[0] = 32'h11223344; wstb[0] = 4'b1111;
        aw_send(4'd1, 32'h1c00_0020, 8'd0, 3'b010, 2'b01);
        w_send(0, 0); b_get();
        wdat[0] = 32'h00aa0000; wstb[0] = 4'b0100;
        aw_send(4'd1, 32'h1c00_0020, 8'd0, 3'b010, 2'b01);
        w_send(0, 0); b_get();
        ar_send(4'd1, 32'h1c00_0020, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t2_rdata", rd_d[0], 32'h11aa3344);
        chk("t2_rid",   {28'b0, rd_id}, 32'd1);

        // 3: 4-beat INCR write, then INCR read with rready 1,0,1,1,0,1
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'h1000_0000 + i; wstb[i] = 4'b1111;
        end
        aw_send(4'd1, 32'h1c00_0000, 8'd3, 3'b010, 2'b01);
        w_send(3, 3); b_get();
        chk("t3_bresp", {30'b0, b_resp}, 32'd0);
        ar_send(4'd1, 32'h1c00_0000, 8'd3, 3'b010, 2'b01);
        r_get(3, 16'h002d);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_data%0d", i), rd_d[i], 32'h1000_0000 + i);
            chk($sformatf("t3_last%0d", i), {31'b0, rd_l[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // FIXED burst re-reads the same word
        ar_send(4'd1, 32'h1c00_0004, 8'd1, 3'b010, 2'b00);
        r_get(1, 16'hffff);
        chk("fx_data0", rd_d[0], 32'h1000_0001);
        chk("fx_data1", rd_d[1], 32'h1000_0001);

        // INCR from the last word of the window wraps to word 0
        wdat[0] = 32'hcafef00d; wstb[0] = 4'b1111;
        aw_send(4'd1, 32'h1c00_fffc, 8'd0, 3'b010, 2'b01);
        w_send(0, 0); b_get();
        ar_send(4'd1, 32'h1c00_fffc, 8'd1, 3'b010, 2'b01);
        r_get(1, 16'hffff);
        chk("wrap_d0", rd_d[0], 32'hcafef00d);
        chk("wrap_d1", rd_d[1], 32'h1000_0000);
        chk("wrap_r1", {30'b0, rd_r[1]}, 32'd0);

        // 5: decode and protocol errors
        ar_send(4'd1, 32'h0000_0000, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t5_dec_resp", {30'b0, rd_r[0]}, 32'd3);
        chk("t5_dec_data", rd_d[0], 32'h0);
        ar_send(4'd1, 32'h1c01_0000, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t5_edge_resp", {30'b0, rd_r[0]}, 32'd3);
        ar_send(4'd1, 32'h1c00_0000, 8'd0, 3'b001, 2'b01);
        r_get(0, 16'hffff);
        chk("t5_size_resp", {30'b0, rd_r[0]}, 32'd2);
        chk("t5_size_data", rd_d[0], 32'h1000_0000);
        wdat[0] = 32'h1; wdat[1] = 32'h2; wstb[0] = 4'b1111; wstb[1] = 4'b1111;
        aw_send(4'd6, 32'h1c00_0040, 8'd1, 3'b010, 2'b01);
        w_send(1, 0); b_get();
        chk("t5_wlast_bresp", {30'b0, b_resp}, 32'd2);
        chk("t5_bid",         {28'b0, b_id},   32'd6);

        // 4: simultaneous AR/AW twice; last grant was a write, so read then write
        arid = 4'd3; araddr = 32'h1c00_0010; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd5; awaddr = 32'h1c00_0030; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        chk("t4a_arready", {31'b0, arready}, 32'd1);
        chk("t4a_awready", {31'b0, awready}, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        r_get(0, 16'hffff);
        chk("t4a_rdata", rd_d[0], 32'hdeadbeef);
        chk("t4a_rid",   {28'b0, rd_id}, 32'd3);
        arvalid = 1'b1;
        @(negedge clk);
        chk("t4b_awready", {31'b0, awready}, 32'd1);
        chk("t4b_arready", {31'b0, arready}, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdat[0] = 32'h0000_4444; wstb[0] = 4'b1111;
        w_send(0, 0); b_get();
        chk("t4b_bid", {28'b0, b_id}, 32'd5);
        ar_send(4'd3, 32'h1c00_0030, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t4c_rdata", rd_d[0], 32'h0000_4444);

        // 6: reset during beat 2 of a 4-beat read, then a fresh read
        ar_send(4'd1, 32'h1c00_0000, 8'd3, 3'b010, 2'b01);
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rready = 1'b1;
        @(negedge clk);
        chk("t6_beat1", rdata, 32'h1000_0000);
        @(posedge clk); #1;
        chk("t6_beat2_valid", {31'b0, rvalid}, 32'd1);
        rst_n = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        chk("t6_rvalid", {31'b0, rvalid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_arready", {31'b0, arready}, 32'd1);
        ar_send(4'd2, 32'h1c00_0010, 8'd0, 3'b010, 2'b01);
        r_get(0, 16'hffff);
        chk("t6_lat",   lat, 32'd2);
        chk("t6_rdata", rd_d[0], 32'hdeadbeef);
        chk("t6_rid",   {28'b0, rd_id}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
